// File: rtl/serial_sub_unit_if.sv
// Handshake and operand/result bundle for serial_sub_unit.
// master drives the request side, slave is the subtractor.
interface serial_sub_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_sub_unit.sv
// Digit-serial subtractor: diff = a - b, DIGIT_W bits per clock, LSB digit first.
// Optional SERIAL_SUB_SAT_EN clamps diff to zero when the subtraction borrows.
//
// state | meaning
// IDLE  | waiting for start; a/b captured on the accepting edge
// BUSY  | one digit per clock, N clocks total
// DONE  | one-cycle done pulse, then back to IDLE
module serial_sub_unit #(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_sub_unit_if.slave   bus
);
    localparam int N  = WIDTH / DIGIT_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [CW-1:0]    count;
    logic             carry;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic [DIGIT_W:0]  sum;
    logic [WIDTH-1:0]  res_next;

    // a + ~b + carry on the current digit; carry starts at 1 for two's complement
    always_comb begin
        sum      = {1'b0, a_sh[DIGIT_W-1:0]} + {1'b0, ~b_sh[DIGIT_W-1:0]}
                 + {{DIGIT_W{1'b0}}, carry};
        res_next = {sum[DIGIT_W-1:0], res_sh[WIDTH-1:DIGIT_W]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            count    <= '0;
            carry    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        res_sh <= '0;
                        count  <= '0;
                        carry  <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    a_sh   <= a_sh >> DIGIT_W;
                    b_sh   <= b_sh >> DIGIT_W;
                    res_sh <= res_next;
                    carry  <= sum[DIGIT_W];
                    count  <= count + CW'(1);
                    if (count == LAST) begin
`ifdef SERIAL_SUB_SAT_EN
                        diff_q <= sum[DIGIT_W] ? res_next : '0;
`else
                        diff_q <= res_next;
`endif
                        // no carry out of the top digit means a < b
                        borrow_q <= ~sum[DIGIT_W];
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_serial_sub_unit.sv
// Directed and randomized bench for serial_sub_unit against an arithmetic model.
module tb_serial_sub_unit;
    localparam int WIDTH = 32;
    localparam int N     = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_sub_unit_if #(.WIDTH(WIDTH)) bus ();

    serial_sub_unit #(.WIDTH(WIDTH), .DIGIT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [WIDTH-1:0] held_diff = '0;

    function automatic logic [WIDTH-1:0] model_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SERIAL_SUB_SAT_EN
        if (a < b) return '0;
`endif
        return a - b;
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to completion; optionally poke start during BUSY.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit poke);
        int cycles;
        int busy_cnt;
        bit got;
        logic [WIDTH-1:0] exp;
        exp = model_diff(a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        check("busy_at_accept", {31'b0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        busy_cnt = 1;
        cycles   = 0;
        got      = 1'b0;
        while (!got && cycles < 3 * N) begin
            @(posedge clk); #1;
            cycles++;
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (bus.busy) busy_cnt++;
                check("diff_hold_busy", bus.diff, held_diff);
                if (poke && cycles == 2) begin
                    bus.start = 1'b1;
                    bus.a     = 32'd1;
                    bus.b     = 32'd1;
                end
                if (poke && cycles == 3) bus.start = 1'b0;
            end
        end
        check("done_seen", {31'b0, got}, 32'd1);
        check("latency", cycles, N);
        check("busy_cycles", busy_cnt, N);
        check("busy_at_done", {31'b0, bus.busy}, 32'd0);
        check("diff", bus.diff, exp);
        check("borrow", {31'b0, bus.borrow}, {31'b0, (a < b)});
        held_diff = exp;
        @(posedge clk); #1;
        check("done_one_cycle", {31'b0, bus.done}, 32'd0);
        check("diff_after_done", bus.diff, exp);
    endtask

    initial begin
        int done_cnt;
        int last_done;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_diff", bus.diff, 32'd0);
        check("rst_borrow", {31'b0, bus.borrow}, 32'd0);
        rst_n = 1'b1;

        run_op(32'd5, 32'd3, 1'b0);
        run_op(32'h0001_0000, 32'd1, 1'b0);
        run_op(32'h0003_CCC0, 32'h0002_CCC1, 1'b0);
        run_op(32'd3, 32'd5, 1'b0);
        run_op(32'd9, 32'd4, 1'b1);
        run_op(32'd1, 32'd1, 1'b0);

        // reset in the middle of an operation discards it
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        held_diff = '0;
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_diff", bus.diff, 32'd0);
        check("midrst_borrow", {31'b0, bus.borrow}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        run_op(32'd7, 32'd7, 1'b0);

        // start held high: one result every N+2 clocks
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd10;
        bus.b     = 32'd4;
        done_cnt  = 0;
        last_done = -1;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            check("no_x", {31'b0, $isunknown({bus.busy, bus.done, bus.diff, bus.borrow})}, 32'd0);
            if (bus.done) begin
                check("cont_busy_done", {31'b0, bus.busy}, 32'd0);
                if (last_done >= 0) check("cont_period", i - last_done, N + 2);
                last_done = i;
                done_cnt++;
            end
            if (done_cnt > 0) check("cont_diff_stable", bus.diff, 32'd6);
        end
        check("cont_pulses", {31'b0, (done_cnt >= 3)}, 32'd1);
        bus.start = 1'b0;
        repeat (N + 3) @(negedge clk);
        held_diff = 32'd6;

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : WIDTH'($urandom);
            run_op(ra, rb, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
